// File: rtl/lzd32_seq.sv
// Sequential 32-bit leading-zero counter and normaliser.
// One shared 8-bit detector walks the operand MSB byte first, then a final cycle shifts it.
module lzd32_seq (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] din_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [5:0]  lzc_o,
  output logic [31:0] norm_out_o,
  output logic        zero_o
);

  typedef enum logic [1:0] {StIdle, StScan, StShift} state_e;

  state_e      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  idx_q, idx_d;
  logic [5:0]  acc_q, acc_d;
  logic [5:0]  lzc_q, lzc_d;
  logic [31:0] norm_q, norm_d;
  logic        zero_q, zero_d;
  logic        done_q, done_d;

  logic [7:0]  byte_sel;
  logic [3:0]  lzd_res;
  logic        scan_last;

  // Highest set bit wins because it is visited last; 8 means the byte is empty.
  function automatic logic [3:0] lzd8(input logic [7:0] b);
    logic [3:0] r;
    r = 4'd8;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = 4'(7 - i);
    end
    return r;
  endfunction

  always_comb begin
    byte_sel = 8'h00;
    unique case (idx_q)
      2'd3: byte_sel = data_q[31:24];
      2'd2: byte_sel = data_q[23:16];
      2'd1: byte_sel = data_q[15:8];
      2'd0: byte_sel = data_q[7:0];
      default: byte_sel = 8'h00;
    endcase
  end

  assign lzd_res   = lzd8(byte_sel);
  assign scan_last = (lzd_res != 4'd8) || (idx_q == 2'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StScan;
      StScan:  if (scan_last) state_d = StShift;
      StShift: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o = (state_q != StIdle);
  end

  always_comb begin
    data_d = data_q;
    idx_d  = idx_q;
    acc_d  = acc_q;
    lzc_d  = lzc_q;
    norm_d = norm_q;
    zero_d = zero_q;
    done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          data_d = din_i;
          idx_d  = 2'd3;
          acc_d  = 6'd0;
        end
      end
      StScan: begin
        acc_d = acc_q + 6'(lzd_res);
        if (!scan_last) idx_d = idx_q - 2'd1;
      end
      StShift: begin
        lzc_d  = acc_q;
        // A count of 32 only happens for a zero operand, so the result is zero.
        norm_d = acc_q[5] ? 32'h0 : (data_q << acc_q[4:0]);
        zero_d = (acc_q == 6'd32);
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= 32'h0;
      idx_q  <= 2'd0;
      acc_q  <= 6'd0;
      lzc_q  <= 6'd0;
      norm_q <= 32'h0;
      zero_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      idx_q  <= idx_d;
      acc_q  <= acc_d;
      lzc_q  <= lzc_d;
      norm_q <= norm_d;
      zero_q <= zero_d;
      done_q <= done_d;
    end
  end

  assign done_o     = done_q;
  assign lzc_o      = lzc_q;
  assign norm_out_o = norm_q;
  assign zero_o     = zero_q;

endmodule

// File: tb/tb_lzd32_seq.sv
// Scoreboard bench for lzd32_seq: expected results queued at start, checked on each done pulse.
module tb_lzd32_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] din;
  logic        busy;
  logic        done;
  logic [5:0]  lzc;
  logic [31:0] norm_out;
  logic        zero;

  lzd32_seq u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .din_i      (din),
    .busy_o     (busy),
    .done_o     (done),
    .lzc_o      (lzc),
    .norm_out_o (norm_out),
    .zero_o     (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  lzc;
    logic [31:0] norm;
    logic        zero;
    int          start_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: plain bit-by-bit scan, independent of the byte-sliced hardware.
  task automatic push_exp(input logic [31:0] d);
    exp_t e;
    int   n;
    e.lzc = 6'd32;
    for (int i = 31; i >= 0; i--) begin
      if (d[i]) begin
        e.lzc = 6'(31 - i);
        break;
      end
    end
    e.norm      = (e.lzc == 6'd32) ? 32'h0 : (d << e.lzc);
    e.zero      = (d == 32'h0);
    n           = (int'(e.lzc) / 8) + 1;
    if (n > 4) n = 4;
    e.lat       = n + 2;
    e.start_cyc = cyc + 1;
    sb.push_back(e);
  endtask

  // Monitor: latency counts the start edge as edge 1; busy spans SCAN cycles plus SHIFT.
  initial begin
    automatic int   busy_cnt = 0;
    automatic exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0;
      end else begin
        if (done) begin
          if (sb.size() == 0) begin
            check_val("spurious_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check_val("lzc", 32'(lzc), 32'(e.lzc));
            check_val("norm_out", norm_out, e.norm);
            check_val("zero", 32'(zero), 32'(e.zero));
            check_val("latency", 32'(cyc - e.start_cyc + 1), 32'(e.lat));
            check_val("busy_at_done", 32'(busy), 32'd0);
            check_val("busy_cycles", 32'(busy_cnt), 32'(e.lat - 1));
          end
          busy_cnt = 0;
        end
        if (busy) busy_cnt++;
      end
    end
  end

  // Called at a negedge; issues start as soon as the block is idle.
  task automatic run_op(input logic [31:0] d);
    int t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (busy) check_val("idle_timeout", 32'd1, 32'd0);
    start = 1'b1;
    din   = d;
    push_exp(d);
    @(negedge clk);
    start = 1'b0;
    din   = $urandom;  // later din changes must not disturb the captured operand
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) check_val("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    int          t;
    rst   = 1'b1;
    start = 1'b0;
    din   = 32'h0;
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_lzc", 32'(lzc), 32'd0);
    check_val("rst_norm", norm_out, 32'd0);
    check_val("rst_zero", 32'(zero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(32'h8000_0000);
    run_op(32'h00F0_0000);
    run_op(32'h0000_0001);
    run_op(32'h0000_0000);
    drain();

    // Start held high through busy: only the done-cycle start is taken.
    start = 1'b1;
    din   = 32'h0000_0001;
    push_exp(din);
    @(negedge clk);
    din = 32'h4000_0000;
    t   = 0;
    while (!done && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!done) check_val("b2b_timeout", 32'd0, 32'd1);
    else push_exp(din);
    @(negedge clk);
    start = 1'b0;
    drain();

    run_op(32'h0000_0001);
    drain();

    // Abort mid-SCAN with an asynchronous reset.
    start = 1'b1;
    din   = 32'h0000_0010;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    check_val("abort_lzc", 32'(lzc), 32'd0);
    check_val("abort_norm", norm_out, 32'd0);
    check_val("abort_zero", 32'(zero), 32'd0);
    @(posedge clk);
    #1 check_val("abort_no_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(32'h0000_1000);
    drain();

    for (int i = 0; i < 200; i++) begin
      d = $urandom;
      d = d >> $urandom_range(0, 32);
      run_op(d);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
